// File: rtl/eth_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_regs_pkg
// Description : Shared constants for the Ethernet AXI4-Lite register file:
//               register byte offsets, ID value, CTRL bit indices, AXI
//               response codes and the MDIO_CMD writable-bit mask.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_regs_pkg;

    // Register byte offsets; the decoder only looks at bits [4:2].
    localparam logic [4:0] c_OFF_CTRL      = 5'h00;
    localparam logic [4:0] c_OFF_MDIO_CMD  = 5'h04;
    localparam logic [4:0] c_OFF_MDIO_STAT = 5'h08;
    localparam logic [4:0] c_OFF_RX_FRAMES = 5'h0C;
    localparam logic [4:0] c_OFF_CRC_ERRS  = 5'h10;
    localparam logic [4:0] c_OFF_SCRATCH   = 5'h14;
    localparam logic [4:0] c_OFF_ID        = 5'h18;
    localparam logic [4:0] c_OFF_UNMAPPED  = 5'h1C;

    localparam logic [31:0] c_ID_VALUE = 32'h4554_4831;

    localparam int unsigned c_CTRL_TX_TEST_BIT = 0;
    localparam int unsigned c_CTRL_RX_EN_BIT   = 1;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // MDIO_CMD keeps [31:16] write data and [10:0] op/phy/reg; [15:11] read 0.
    localparam logic [31:0] c_MDIO_CMD_MASK = 32'hFFFF_07FF;

endpackage : eth_regs_pkg
`default_nettype wire

// File: rtl/eth_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : eth_sat_counter
// Description : 32-bit saturating event counter with synchronous clear.
//               A clear in the same cycle as an increment leaves the count at
//               1 so that the coincident event is not lost.
// Ports       : clk, rst_n (async active-low), i_inc (event strobe),
//               i_clr (clear strobe), o_count (current count)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_clr,
    output logic [31:0] o_count
);

    logic [31:0] r_cnt_q;
    logic [31:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = {31'd0, i_inc};
        end else if (i_inc && (r_cnt_q != 32'hFFFF_FFFF)) begin
            w_cnt_d = r_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q <= 32'd0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_count = r_cnt_q;

endmodule : eth_sat_counter
`default_nettype wire

// File: rtl/eth_axi_regs.sv
`default_nettype none
// ============================================================================
// Module      : eth_axi_regs
// Description : AXI4-Lite slave register file controlling the Ethernet block:
//               CTRL, MDIO command/status, saturating RX frame and CRC error
//               counters, scratch and ID registers.
// Ports       : AXI_Clk / AXI_Rstn      - clock, async active-low reset
//               AXI_aw*/w*/b*           - write address/data/response
//               AXI_ar*/r*              - read address/data
//               Tx_Test_En, Rx_En       - CTRL bits
//               Mdio_*                  - MDIO master command/status
//               Rx_Frame_Pulse,
//               Crc_Err_Pulse           - synchronised event strobes
// Revision    : 1.0 - initial release
// ============================================================================
module eth_axi_regs
    import eth_regs_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] ID_VALUE = c_ID_VALUE
) (
    input  logic              AXI_Clk,
    input  logic              AXI_Rstn,
    input  logic              AXI_awvalid,
    output logic              AXI_awready,
    input  logic [ADDR_W-1:0] AXI_awaddr,
    input  logic              AXI_wvalid,
    output logic              AXI_wready,
    input  logic [31:0]       AXI_wdata,
    output logic              AXI_bvalid,
    output logic [1:0]        AXI_bresp,
    input  logic              AXI_bready,
    input  logic              AXI_arvalid,
    output logic              AXI_arready,
    input  logic [ADDR_W-1:0] AXI_araddr,
    output logic              AXI_rvalid,
    output logic [31:0]       AXI_rdata,
    output logic [1:0]        AXI_rresp,
    input  logic              AXI_rready,
    output logic              Tx_Test_En,
    output logic              Rx_En,
    output logic              Mdio_Start,
    output logic              Mdio_Op,
    output logic [4:0]        Mdio_Phy_Addr,
    output logic [4:0]        Mdio_Reg_Addr,
    output logic [15:0]       Mdio_Wr_Data,
    input  logic              Mdio_Busy,
    input  logic [15:0]       Mdio_Rd_Data,
    input  logic              Rx_Frame_Pulse,
    input  logic              Crc_Err_Pulse
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_awready_q, w_awready_d;
    logic        r_wready_q,  w_wready_d;
    logic        r_arready_q, w_arready_d;
    logic        r_aw_held_q, w_aw_held_d;
    logic        r_w_held_q,  w_w_held_d;
    logic [2:0]  r_awidx_q,   w_awidx_d;
    logic [31:0] r_wdata_q,   w_wdata_d;
    logic        r_bvalid_q,  w_bvalid_d;
    logic [1:0]  r_bresp_q,   w_bresp_d;
    logic        r_rvalid_q,  w_rvalid_d;
    logic [31:0] r_rdata_q,   w_rdata_d;
    logic [1:0]  r_rresp_q,   w_rresp_d;
    logic [1:0]  r_ctrl_q,    w_ctrl_d;
    logic [31:0] r_mdio_cmd_q, w_mdio_cmd_d;
    logic [31:0] r_scratch_q, w_scratch_d;
    logic        r_mdio_go_q, w_mdio_go_d;
    logic        r_mdio_start_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_ar_fire;
    logic        w_do_write;
    logic [2:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [1:0]  w_wr_resp;
    logic [2:0]  w_rd_idx;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_rx_clr;
    logic        w_crc_clr;
    logic [31:0] w_rx_count;
    logic [31:0] w_crc_count;
    logic        w_unused_addr_bits;

    // Only addr[4:2] is decoded; the rest is deliberately ignored.
    assign w_unused_addr_bits = &{1'b0, AXI_awaddr, AXI_araddr};

    always_comb begin
        w_aw_fire  = AXI_awvalid & r_awready_q;
        w_w_fire   = AXI_wvalid  & r_wready_q;
        w_ar_fire  = AXI_arvalid & r_arready_q;

        // A beat arriving now is used directly; a beat that arrived earlier
        // comes from its holding register.
        w_wr_idx   = r_aw_held_q ? r_awidx_q : AXI_awaddr[4:2];
        w_wr_data  = r_w_held_q  ? r_wdata_q : AXI_wdata;
        w_do_write = (r_aw_held_q | w_aw_fire) & (r_w_held_q | w_w_fire);

        w_ctrl_d     = r_ctrl_q;
        w_mdio_cmd_d = r_mdio_cmd_q;
        w_scratch_d  = r_scratch_q;
        w_mdio_go_d  = 1'b0;
        w_rx_clr     = 1'b0;
        w_crc_clr    = 1'b0;
        w_wr_resp    = c_RESP_OKAY;

        if (w_do_write) begin
            case (w_wr_idx)
                c_OFF_CTRL[4:2]: begin
                    w_ctrl_d = w_wr_data[1:0];
                end
                c_OFF_MDIO_CMD[4:2]: begin
                    // A command while the MDIO master is busy is refused.
                    if (Mdio_Busy) begin
                        w_wr_resp = c_RESP_SLVERR;
                    end else begin
                        w_mdio_cmd_d = w_wr_data & c_MDIO_CMD_MASK;
                        w_mdio_go_d  = 1'b1;
                    end
                end
                c_OFF_RX_FRAMES[4:2]: w_rx_clr  = 1'b1;
                c_OFF_CRC_ERRS[4:2]:  w_crc_clr = 1'b1;
                c_OFF_SCRATCH[4:2]:   w_scratch_d = w_wr_data;
                c_OFF_UNMAPPED[4:2]:  w_wr_resp = c_RESP_SLVERR;
                default: ;
            endcase
        end

        w_aw_held_d = ~w_do_write & (r_aw_held_q | w_aw_fire);
        w_w_held_d  = ~w_do_write & (r_w_held_q  | w_w_fire);
        w_awidx_d   = w_aw_fire ? AXI_awaddr[4:2] : r_awidx_q;
        w_wdata_d   = w_w_fire  ? AXI_wdata       : r_wdata_q;

        w_bvalid_d = r_bvalid_q;
        w_bresp_d  = r_bresp_q;
        if (w_do_write) begin
            w_bvalid_d = 1'b1;
            w_bresp_d  = w_wr_resp;
        end else if (r_bvalid_q && AXI_bready) begin
            w_bvalid_d = 1'b0;
        end

        // Ready flags are registered so they stay low through reset and rise
        // on the first edge after it.
        w_awready_d = ~w_aw_held_d & ~w_bvalid_d;
        w_wready_d  = ~w_w_held_d  & ~w_bvalid_d;

        // Read mux. Counters are read before any same-cycle clear lands.
        w_rd_idx  = AXI_araddr[4:2];
        w_rd_resp = c_RESP_OKAY;
        case (w_rd_idx)
            c_OFF_CTRL[4:2]:      w_rd_data = {30'd0, r_ctrl_q};
            c_OFF_MDIO_CMD[4:2]:  w_rd_data = r_mdio_cmd_q;
            c_OFF_MDIO_STAT[4:2]: w_rd_data = {Mdio_Rd_Data, 15'd0, Mdio_Busy};
            c_OFF_RX_FRAMES[4:2]: w_rd_data = w_rx_count;
            c_OFF_CRC_ERRS[4:2]:  w_rd_data = w_crc_count;
            c_OFF_SCRATCH[4:2]:   w_rd_data = r_scratch_q;
            c_OFF_ID[4:2]:        w_rd_data = ID_VALUE;
            default: begin
                w_rd_data = 32'd0;
                w_rd_resp = c_RESP_SLVERR;
            end
        endcase

        w_rvalid_d = r_rvalid_q;
        w_rdata_d  = r_rdata_q;
        w_rresp_d  = r_rresp_q;
        if (w_ar_fire) begin
            w_rvalid_d = 1'b1;
            w_rdata_d  = w_rd_data;
            w_rresp_d  = w_rd_resp;
        end else if (r_rvalid_q && AXI_rready) begin
            w_rvalid_d = 1'b0;
        end
        w_arready_d = ~w_rvalid_d;
    end

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            r_awready_q    <= 1'b0;
            r_wready_q     <= 1'b0;
            r_arready_q    <= 1'b0;
            r_aw_held_q    <= 1'b0;
            r_w_held_q     <= 1'b0;
            r_awidx_q      <= 3'd0;
            r_wdata_q      <= 32'd0;
            r_bvalid_q     <= 1'b0;
            r_bresp_q      <= c_RESP_OKAY;
            r_rvalid_q     <= 1'b0;
            r_rdata_q      <= 32'd0;
            r_rresp_q      <= c_RESP_OKAY;
            r_ctrl_q       <= 2'd0;
            r_mdio_cmd_q   <= 32'd0;
            r_scratch_q    <= 32'd0;
            r_mdio_go_q    <= 1'b0;
            r_mdio_start_q <= 1'b0;
        end else begin
            r_awready_q    <= w_awready_d;
            r_wready_q     <= w_wready_d;
            r_arready_q    <= w_arready_d;
            r_aw_held_q    <= w_aw_held_d;
            r_w_held_q     <= w_w_held_d;
            r_awidx_q      <= w_awidx_d;
            r_wdata_q      <= w_wdata_d;
            r_bvalid_q     <= w_bvalid_d;
            r_bresp_q      <= w_bresp_d;
            r_rvalid_q     <= w_rvalid_d;
            r_rdata_q      <= w_rdata_d;
            r_rresp_q      <= w_rresp_d;
            r_ctrl_q       <= w_ctrl_d;
            r_mdio_cmd_q   <= w_mdio_cmd_d;
            r_scratch_q    <= w_scratch_d;
            r_mdio_go_q    <= w_mdio_go_d;
            // Start strobe trails the commit by one cycle, from a flop.
            r_mdio_start_q <= r_mdio_go_q;
        end
    end

    eth_sat_counter u_rx_frames (
        .clk     (AXI_Clk),
        .rst_n   (AXI_Rstn),
        .i_inc   (Rx_Frame_Pulse),
        .i_clr   (w_rx_clr),
        .o_count (w_rx_count)
    );

    eth_sat_counter u_crc_errs (
        .clk     (AXI_Clk),
        .rst_n   (AXI_Rstn),
        .i_inc   (Crc_Err_Pulse),
        .i_clr   (w_crc_clr),
        .o_count (w_crc_count)
    );

    assign AXI_awready   = r_awready_q;
    assign AXI_wready    = r_wready_q;
    assign AXI_arready   = r_arready_q;
    assign AXI_bvalid    = r_bvalid_q;
    assign AXI_bresp     = r_bresp_q;
    assign AXI_rvalid    = r_rvalid_q;
    assign AXI_rdata     = r_rdata_q;
    assign AXI_rresp     = r_rresp_q;
    assign Tx_Test_En    = r_ctrl_q[c_CTRL_TX_TEST_BIT];
    assign Rx_En         = r_ctrl_q[c_CTRL_RX_EN_BIT];
    assign Mdio_Start    = r_mdio_start_q;
    assign Mdio_Op       = r_mdio_cmd_q[10];
    assign Mdio_Phy_Addr = r_mdio_cmd_q[9:5];
    assign Mdio_Reg_Addr = r_mdio_cmd_q[4:0];
    assign Mdio_Wr_Data  = r_mdio_cmd_q[31:16];

endmodule : eth_axi_regs
`default_nettype wire

// File: doc/eth_axi_regs.md
# eth_axi_regs

AXI4-Lite slave register file between the PS AXI master port (M_AXI_0) and the Ethernet datapath inside eth_top. Software uses it to control the Ethernet block, launch MDIO transactions, read MDIO results and read saturating RX frame and CRC-error counters. All logic runs in the AXI clock domain. Event inputs arrive already synchronised to AXI_Clk.

## Interface
Parameters:
- ADDR_W, 32, AXI address width; only addr[4:2] is decoded, addr[1:0] is ignored.
- ID_VALUE, 32'h4554_4831, constant returned by the ID register.

Ports:
- AXI_Clk  in  1  AXI clock; the only clock.
- AXI_Rstn  in  1  asynchronous, active-low reset.
- AXI_awvalid/AXI_awready  in/out  1  write-address handshake; AXI_awaddr  in  ADDR_W.
- AXI_wvalid/AXI_wready  in/out  1  write-data handshake; AXI_wdata  in  32. There is no strobe: every write is a full-word write.
- AXI_bvalid  out  1, AXI_bresp  out  2, AXI_bready  in  1  write response.
- AXI_arvalid/AXI_arready  in/out  1  read-address handshake; AXI_araddr  in  ADDR_W.
- AXI_rvalid  out  1, AXI_rdata  out  32, AXI_rresp  out  2, AXI_rready  in  1  read data.
- Tx_Test_En  out  1  CTRL[0].
- Rx_En  out  1  CTRL[1].
- Mdio_Start  out  1  single-cycle command strobe.
- Mdio_Op  out  1  1 = read, 0 = write.
- Mdio_Phy_Addr  out  5; Mdio_Reg_Addr  out  5; Mdio_Wr_Data  out  16.
- Mdio_Busy  in  1; Mdio_Rd_Data  in  16  from the MDIO master.
- Rx_Frame_Pulse  in  1; Crc_Err_Pulse  in  1  single-cycle event strobes.

## Operation
Register map (byte offset):
- 0x00 CTRL, RW: [0] tx test enable, [1] rx enable; other bits read 0.
- 0x04 MDIO_CMD, RW: [4:0] reg addr, [9:5] phy addr, [10] op, [31:16] write data.
  - A write while Mdio_Busy=0 updates the register and pulses Mdio_Start in the cycle after the write commits.
  - A write while Mdio_Busy=1 returns SLVERR, does not update the register and produces no pulse.
- 0x08 MDIO_STAT, RO: [0] Mdio_Busy, [31:16] Mdio_Rd_Data, both sampled at read-address handshake.
- 0x0C RX_FRAMES, 32-bit saturating counter of Rx_Frame_Pulse.
  - A write of any value clears it.
- 0x10 CRC_ERRS, 32-bit saturating counter of Crc_Err_Pulse.
  - A write of any value clears it.
- 0x14 SCRATCH, RW, no side effects.
- 0x18 ID, RO: ID_VALUE; writes are ignored with OKAY.
- 0x1C unmapped: reads return 0 with SLVERR; writes are ignored with SLVERR.

Write channel:
- AW and W are accepted independently, in either order or in the same cycle.
- Each accepted beat is latched until its partner arrives.
- The register update occurs in the cycle after both are held.
- AXI_bvalid rises in that same cycle (commit cycle) and holds until AXI_bready.
- awready=0 while an address is held or B is pending; wready=0 while data is held or B is pending.

Read channel:
- arready=1 whenever rvalid=0.
- rdata and rresp are registered at the handshake.
- rvalid holds with stable data until AXI_rready.

Counters:
- A pulse increments the counter; at 0xFFFF_FFFF the counter stays there.
- A clear coincident with a pulse leaves the counter at 1.
- A read coincident with a clear of the same counter returns the pre-clear value.

Reset values: CTRL=0, MDIO_CMD=0, SCRATCH=0, counters=0, all ready/valid outputs=0, bresp=rresp=0, rdata=0, Mdio_Start=0.

## Timing
- awready, wready and arready rise in the first cycle after reset deassertion.
- Write: a simultaneous AW+W handshake in cycle N commits in N+1, with bvalid=1 from N+1. Next AW is accepted no earlier than the cycle after the bready handshake.
- Read: handshake in cycle N gives rvalid=1 at N+1. With rready held at 1, a read completes every 2 cycles.
- Mdio_Start is high for exactly one cycle, at commit+1, registered.
- Mdio_Busy is sampled in the commit cycle.
- A reset assertion mid-transaction drops all valids and held beats immediately; no partial write completes.

## Structure
- Package eth_regs_pkg holds register offsets, ID_VALUE, CTRL bit indices and AXI response constants (OKAY 2'b00, SLVERR 2'b10).
- Sub-module eth_sat_counter (32-bit, inc/clr, clear-with-inc = 1) is instantiated twice.

## Test plan
- Write SCRATCH 0xDEADBEEF with AW two cycles before W, then read it back → bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY.
- Write CTRL 0x3 → Tx_Test_En=1, Rx_En=1. Read ID → 0x45544831.
- With Mdio_Busy=0, write MDIO_CMD 0xABCD_0423 → one-cycle Mdio_Start, Op=1, Phy=1, Reg=3, Wr_Data=0xABCD. Repeat with Busy=1 → SLVERR, no pulse, register unchanged.
- Apply 5 Rx_Frame_Pulse → RX_FRAMES reads 5. Write clear coincident with a pulse → then reads 1. Force the counter to 0xFFFFFFFF, pulse → stays 0xFFFFFFFF.
- Read 0x1C → rdata=0, SLVERR. Hold bready=0 for 10 cycles → bvalid stays 1 and awready stays 0.
- Assert reset with AW held but W absent, then write SCRATCH 0x1 → no stale commit, SCRATCH=0x1.
